// File: rtl/sisc_pkg.sv
// Shared constants for the SISC controller: opcodes, FSM state encoding,
// ALU operation codes and the bundled control-output record.
package sisc_pkg;

  localparam int OPC_NOOP   = 0;
  localparam int OPC_REG_OP = 1;
  localparam int OPC_REG_IM = 2;
  localparam int OPC_BRA    = 4;
  localparam int OPC_BRR    = 5;
  localparam int OPC_BNE    = 6;
  localparam int OPC_BNR    = 7;
  localparam int OPC_LOD    = 8;
  localparam int OPC_STR    = 9;
  localparam int OPC_HLT    = 15;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  localparam logic [1:0] ALU_HOLD = 2'b00;
  localparam logic [1:0] ALU_ADDR = 2'b01;
  localparam logic [1:0] ALU_RR   = 2'b10;
  localparam logic [1:0] ALU_RI   = 2'b11;

  typedef struct packed {
    logic       pc_rst;
    logic       ir_load;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic [1:0] alu_op;
    logic       stat_en;
    logic       mm_sel;
    logic       dm_we;
    logic       rf_we;
    logic       wb_sel;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/sisc_ctrl_gen_if.sv
// Bundle of IR fields, status, memory handshake and control strobes between
// the SISC controller (master) and the datapath (slave).
interface sisc_ctrl_gen_if #(
  parameter int OP_W   = 4,
  parameter int STAT_W = 4
);
  logic [OP_W-1:0]   opcode;
  logic [STAT_W-1:0] mm;
  logic [STAT_W-1:0] stat;
  logic              mem_rdy;
  logic              pc_rst;
  logic              ir_load;
  logic              pc_write;
  logic              pc_sel;
  logic              br_sel;
  logic [1:0]        alu_op;
  logic              stat_en;
  logic              mm_sel;
  logic              dm_we;
  logic              rf_we;
  logic              wb_sel;
  logic              halted;
  logic              mem_err;
  logic [2:0]        state_o;

  modport master (
    input  opcode, mm, stat, mem_rdy,
    output pc_rst, ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en,
           mm_sel, dm_we, rf_we, wb_sel, halted, mem_err, state_o
  );

  modport slave (
    output opcode, mm, stat, mem_rdy,
    input  pc_rst, ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en,
           mm_sel, dm_we, rf_we, wb_sel, halted, mem_err, state_o
  );
endinterface

// File: rtl/sisc_br_eval.sv
// Branch condition: any masked status bit set means "hit"; the negated
// branch forms take the branch when nothing in the mask is set.
module sisc_br_eval #(
  parameter int STAT_W = 4
) (
  input  logic [STAT_W-1:0] i_stat,
  input  logic [STAT_W-1:0] i_mm,
  input  logic              i_neg,
  output logic              o_taken
);
  logic w_hit;

  assign w_hit   = |(i_stat & i_mm);
  assign o_taken = i_neg ? ~w_hit : w_hit;
endmodule

// File: rtl/sisc_ctrl_gen.sv
// SISC control-signal generator: Moore FSM sequencing fetch/decode/execute,
// optional memory access with timeout, and writeback.
//
//   state     | meaning
//   START0    | PC held in reset
//   START1    | one settling cycle after PC reset
//   FETCH     | load IR, advance PC
//   DECODE    | capture opcode/mask; HLT goes straight to HALT
//   EXECUTE   | ALU op or branch resolution
//   MEM       | data memory access, waits for mem_rdy with timeout
//   WRITEBACK | register file update
//   HALT      | absorbing until reset
module sisc_ctrl_gen
  import sisc_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int STAT_W = 4,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  sisc_ctrl_gen_if.master bus
);
  localparam int              CNT_W  = (MEM_TO < 1) ? 1 : $clog2(MEM_TO + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TO);

  state_t            r_state;
  state_t            w_next;
  logic [OP_W-1:0]   r_op;
  logic [STAT_W-1:0] r_mm;
  logic [CNT_W-1:0]  r_wait;
  logic              r_mem_err;
  ctrl_t             w_ctrl;

  logic w_is_reg_op, w_is_reg_im, w_is_lod, w_is_str, w_is_mem;
  logic w_is_bra, w_is_brr, w_is_bne, w_is_bnr, w_is_br;
  logic w_br_neg, w_br_rel, w_taken, w_dec_hlt, w_wait_tc, w_timeout;

  assign w_is_reg_op = (r_op == OP_W'(OPC_REG_OP));
  assign w_is_reg_im = (r_op == OP_W'(OPC_REG_IM));
  assign w_is_lod    = (r_op == OP_W'(OPC_LOD));
  assign w_is_str    = (r_op == OP_W'(OPC_STR));
  assign w_is_bra    = (r_op == OP_W'(OPC_BRA));
  assign w_is_brr    = (r_op == OP_W'(OPC_BRR));
  assign w_is_bne    = (r_op == OP_W'(OPC_BNE));
  assign w_is_bnr    = (r_op == OP_W'(OPC_BNR));
  assign w_is_mem    = w_is_lod | w_is_str;
  assign w_is_br     = w_is_bra | w_is_brr | w_is_bne | w_is_bnr;
  assign w_br_neg    = w_is_bne | w_is_bnr;
  assign w_br_rel    = w_is_brr | w_is_bnr;

  // HLT is recognised from the live opcode while it is being captured.
  assign w_dec_hlt   = (bus.opcode == OP_W'(OPC_HLT));
  assign w_wait_tc   = (r_wait == TO_VAL);
  assign w_timeout   = (r_state == ST_MEM) && !bus.mem_rdy && w_wait_tc;

  sisc_br_eval #(.STAT_W(STAT_W)) u_br_eval (
    .i_stat  (bus.stat),
    .i_mm    (r_mm),
    .i_neg   (w_br_neg),
    .o_taken (w_taken)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) r_state <= ST_START0;
    else        r_state <= w_next;
  end

  // Capture instruction fields once per instruction, in DECODE.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_op <= '0;
      r_mm <= '0;
    end else if (r_state == ST_DECODE) begin
      r_op <= bus.opcode;
      r_mm <= bus.mm;
    end
  end

  // Memory wait counter: cleared on the way into MEM, stops at the timeout value.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                                                 r_wait <= '0;
    else if (r_state == ST_EXECUTE)                             r_wait <= '0;
    else if (r_state == ST_MEM && !bus.mem_rdy && !w_wait_tc)   r_wait <= r_wait + 1'b1;
  end

  // Sticky timeout flag, only cleared by reset.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)         r_mem_err <= 1'b0;
    else if (w_timeout) r_mem_err <= 1'b1;
  end

  // Next-state decision.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START0:    w_next = ST_START1;
      ST_START1:    w_next = ST_FETCH;
      ST_FETCH:     w_next = ST_DECODE;
      ST_DECODE:    w_next = w_dec_hlt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   w_next = w_is_mem ? ST_MEM : ST_WRITEBACK;
      ST_MEM: begin
        if (bus.mem_rdy)    w_next = ST_WRITEBACK;
        else if (w_wait_tc) w_next = ST_HALT;
      end
      ST_WRITEBACK: w_next = ST_FETCH;
      ST_HALT:      w_next = ST_HALT;
      default:      w_next = ST_START0;
    endcase
  end

  // Moore control outputs from state, latched fields and live status.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_START0: w_ctrl.pc_rst = 1'b1;
      ST_FETCH: begin
        w_ctrl.ir_load  = 1'b1;
        w_ctrl.pc_write = 1'b1;
      end
      ST_EXECUTE: begin
        if (w_is_reg_op) begin
          w_ctrl.alu_op  = ALU_RR;
          w_ctrl.stat_en = 1'b1;
        end else if (w_is_reg_im) begin
          w_ctrl.alu_op  = ALU_RI;
          w_ctrl.stat_en = 1'b1;
        end else if (w_is_mem) begin
          w_ctrl.alu_op  = ALU_ADDR;
        end else if (w_is_br && w_taken) begin
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_sel   = 1'b1;
          w_ctrl.br_sel   = w_br_rel;
        end
      end
      ST_MEM: begin
        w_ctrl.mm_sel = 1'b1;
        w_ctrl.dm_we  = w_is_str;
      end
      ST_WRITEBACK: begin
        w_ctrl.rf_we  = w_is_reg_op | w_is_reg_im | w_is_lod;
        w_ctrl.wb_sel = w_is_lod;
        w_ctrl.mm_sel = w_is_lod;
      end
      ST_HALT: w_ctrl.halted = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  assign bus.pc_rst   = w_ctrl.pc_rst;
  assign bus.ir_load  = w_ctrl.ir_load;
  assign bus.pc_write = w_ctrl.pc_write;
  assign bus.pc_sel   = w_ctrl.pc_sel;
  assign bus.br_sel   = w_ctrl.br_sel;
  assign bus.alu_op   = w_ctrl.alu_op;
  assign bus.stat_en  = w_ctrl.stat_en;
  assign bus.mm_sel   = w_ctrl.mm_sel;
  assign bus.dm_we    = w_ctrl.dm_we;
  assign bus.rf_we    = w_ctrl.rf_we;
  assign bus.wb_sel   = w_ctrl.wb_sel;
  assign bus.halted   = w_ctrl.halted;
  assign bus.mem_err  = r_mem_err;
  assign bus.state_o  = r_state;
endmodule

// File: tb/tb_sisc_ctrl_gen.sv
// Bench for sisc_ctrl_gen: an instruction-level model pushes the expected
// per-cycle outputs into a queue; a monitor compares them on each falling edge.
module tb_sisc_ctrl_gen;
  localparam int MEM_TO = 15;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_rst;
    logic       ir_load;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic [1:0] alu_op;
    logic       stat_en;
    logic       mm_sel;
    logic       dm_we;
    logic       rf_we;
    logic       wb_sel;
    logic       halted;
    logic       mem_err;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_f = 1'b0;

  sisc_ctrl_gen_if #(.OP_W(4), .STAT_W(4)) bus ();

  sisc_ctrl_gen #(.OP_W(4), .STAT_W(4), .MEM_TO(MEM_TO)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t exq[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   slot_no = 0;
  bit   m_err   = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.st       = bus.state_o;
    o.pc_rst   = bus.pc_rst;
    o.ir_load  = bus.ir_load;
    o.pc_write = bus.pc_write;
    o.pc_sel   = bus.pc_sel;
    o.br_sel   = bus.br_sel;
    o.alu_op   = bus.alu_op;
    o.stat_en  = bus.stat_en;
    o.mm_sel   = bus.mm_sel;
    o.dm_we    = bus.dm_we;
    o.rf_we    = bus.rf_we;
    o.wb_sel   = bus.wb_sel;
    o.halted   = bus.halted;
    o.mem_err  = bus.mem_err;
    return o;
  endfunction

  // Monitor: compare every presented cycle against the model's expectation.
  initial begin
    obs_t e, g;
    int   k = 0;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        g = sample();
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle_outputs #%0d: got state=%0d vec=%h, required state=%0d vec=%h",
                   k, g.st, g, e.st, e);
        end
        k++;
      end
    end
  end

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic obs_t base(input int st);
    obs_t e = '0;
    e.st      = 3'(st);
    e.mem_err = m_err;
    return e;
  endfunction

  task automatic slot(input logic rv, input logic [3:0] op, input logic [3:0] mmv,
                      input logic [3:0] stv, input logic rdy, input obs_t e);
    @(posedge clk);
    #1;
    rst_f       = rv;
    bus.opcode  = op;
    bus.mm      = mmv;
    bus.stat    = stv;
    bus.mem_rdy = rdy;
    exq.push_back(e);
    slot_no++;
  endtask

  task automatic do_reset();
    obs_t e;
    m_err = 1'b0;
    e = base(0);
    e.pc_rst = 1'b1;
    repeat (2) slot(1'b0, rnd4(), rnd4(), rnd4(), 1'($urandom), e);
    slot(1'b1, rnd4(), rnd4(), rnd4(), 1'($urandom), e);
    e = base(1);
    slot(1'b1, rnd4(), rnd4(), rnd4(), 1'($urandom), e);
  endtask

  task automatic halt_slots(input int n);
    obs_t e;
    e = base(7);
    e.halted = 1'b1;
    repeat (n) slot(1'b1, rnd4(), rnd4(), rnd4(), 1'($urandom), e);
  endtask

  // One instruction from FETCH onward. stat_x<0 means random status in EXECUTE;
  // waits = MEM cycles with mem_rdy low before it rises; abort_k = MEM cycle
  // index at which reset is pulsed (-1 for none).
  task automatic instr(input int op, input logic [3:0] mmv, input int stat_x,
                       input int waits, input int abort_k);
    obs_t       e;
    logic [3:0] stv;
    logic       hit, taken, rdy;
    e = base(2);
    e.ir_load  = 1'b1;
    e.pc_write = 1'b1;
    slot(1'b1, 4'(op), mmv, rnd4(), 1'($urandom), e);
    e = base(3);
    slot(1'b1, 4'(op), mmv, rnd4(), 1'($urandom), e);
    if (op == 15) begin
      halt_slots(20);
      return;
    end
    stv = (stat_x < 0) ? rnd4() : 4'(stat_x);
    e = base(4);
    case (op)
      1: begin e.alu_op = 2'b10; e.stat_en = 1'b1; end
      2: begin e.alu_op = 2'b11; e.stat_en = 1'b1; end
      8, 9: e.alu_op = 2'b01;
      4, 5, 6, 7: begin
        hit   = ((stv & mmv) != 4'd0);
        taken = (op == 4 || op == 5) ? hit : !hit;
        if (taken) begin
          e.pc_write = 1'b1;
          e.pc_sel   = 1'b1;
          e.br_sel   = (op == 5 || op == 7);
        end
      end
      default: ;
    endcase
    slot(1'b1, rnd4(), rnd4(), stv, 1'($urandom), e);
    if (op == 8 || op == 9) begin
      for (int k = 0; k <= MEM_TO; k++) begin
        if (k == abort_k) begin
          do_reset();
          return;
        end
        rdy = (k == waits);
        e = base(5);
        e.mm_sel = 1'b1;
        e.dm_we  = (op == 9);
        slot(1'b1, rnd4(), rnd4(), rnd4(), rdy, e);
        if (rdy) break;
        if (k == MEM_TO) begin
          m_err = 1'b1;
          halt_slots(4);
          return;
        end
      end
    end
    e = base(6);
    e.rf_we  = (op == 1 || op == 2 || op == 8);
    e.wb_sel = (op == 8);
    e.mm_sel = (op == 8);
    slot(1'b1, rnd4(), rnd4(), rnd4(), 1'($urandom), e);
  endtask

  initial begin
    int op;
    bus.opcode  = '0;
    bus.mm      = '0;
    bus.stat    = '0;
    bus.mem_rdy = 1'b0;

    do_reset();
    instr(1, rnd4(), -1, 0, -1);
    instr(1, rnd4(), -1, 0, -1);
    instr(6, 4'b0001, 0, 0, -1);
    instr(6, 4'b0001, 1, 0, -1);
    instr(7, 4'b0100, 0, 0, -1);
    instr(4, 4'b1000, 8, 0, -1);
    instr(5, 4'b0010, 0, 0, -1);
    instr(8, rnd4(), -1, 3, -1);
    instr(9, rnd4(), -1, 2, -1);
    instr(9, rnd4(), -1, MEM_TO, -1);
    instr(8, rnd4(), -1, MEM_TO, -1);
    instr(2, rnd4(), -1, 0, -1);
    instr(12, rnd4(), -1, 0, -1);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 14);
      instr(op, rnd4(), -1, $urandom_range(0, 4), -1);
    end

    instr(15, rnd4(), -1, 0, -1);
    do_reset();
    instr(9, rnd4(), -1, 1000, -1);
    do_reset();
    instr(1, rnd4(), -1, 0, -1);
    instr(8, rnd4(), -1, 1000, 2);
    instr(9, rnd4(), -1, 1000, 5);
    instr(2, rnd4(), -1, 0, -1);
    instr(8, rnd4(), -1, 1000, -1);

    for (int i = 0; i < 10 && exq.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", exq.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sisc_ctrl_gen.md
SISC_CTRL_GEN -- requirements
Module: sisc_ctrl_gen

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have parameter STAT_W, default 4, status/condition-mask width (mm width equals STAT_W).
REQ-003 SHALL have parameter MEM_TO, default 15, maximum MEM wait cycles before error.
REQ-004 SHALL have one clock, clk; reset rst_f is asynchronous, active-low.
REQ-005 Ports SHALL be:
clk  in  1  clock.
rst_f  in  1  async active-low reset.
opcode  in  OP_W  IR opcode field.
mm  in  STAT_W  IR condition mask.
stat  in  STAT_W  status register (C,N,V,Z).
mem_rdy  in  1  data memory ready.
pc_rst  out  1  PC reset.
ir_load  out  1  IR load.
pc_write  out  1  PC update.
pc_sel  out  1  0=PC+1, 1=branch target.
br_sel  out  1  0=absolute, 1=relative target.
alu_op  out  2  00 hold, 01 address calc, 10 reg-reg, 11 reg-imm.
stat_en  out  1  status register load.
mm_sel  out  1  memory address path select.
dm_we  out  1  data memory write.
rf_we  out  1  register file write.
wb_sel  out  1  0=ALU, 1=memory writeback.
halted  out  1  HALT state.
mem_err  out  1  sticky memory timeout.
state_o  out  3  current state encoding.

Function
REQ-006 Opcodes SHALL be NOOP=0, REG_OP=1, REG_IM=2, BRA=4, BRR=5, BNE=6, BNR=7, LOD=8, STR=9, HLT=F; others SHALL behave as NOOP.
REQ-007 States SHALL be START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; state_o SHALL encode them 0..7 in that order.
REQ-008 Transitions SHALL be START0->START1->FETCH->DECODE, one clock each.
REQ-009 DECODE SHALL latch opcode and mm; later states SHALL use latched values only; DECODE->HALT on HLT, else ->EXECUTE.
REQ-010 EXECUTE->MEM for LOD/STR, else ->WRITEBACK; MEM->WRITEBACK on mem_rdy=1; WRITEBACK->FETCH; HALT SHALL be absorbing until reset.
REQ-011 Outputs SHALL be Moore-style (state, latched fields, live stat); all outputs SHALL default 0 in every state.
REQ-012 START0: pc_rst=1. FETCH: ir_load=1, pc_write=1, pc_sel=0.
REQ-013 EXECUTE: alu_op=10 and stat_en=1 for REG_OP; alu_op=11 and stat_en=1 for REG_IM; alu_op=01 for LOD/STR.
REQ-014 EXECUTE branch: BRA/BRR taken when (stat & mm)!=0; BNE/BNR taken when (stat & mm)==0; taken: pc_write=1, pc_sel=1; br_sel=1 for BRR/BNR, 0 for BRA/BNE; not taken: pc_write=0.
REQ-015 MEM: mm_sel=1 every cycle; STR: dm_we=1 every MEM cycle, write commits on the cycle mem_rdy=1.
REQ-016 WRITEBACK: rf_we=1 for REG_OP, REG_IM, LOD; wb_sel=1 for LOD only; mm_sel=1 for LOD.
REQ-017 Wait counter SHALL clear on MEM entry and count each MEM cycle with mem_rdy=0; when it reaches MEM_TO with mem_rdy still 0, next state SHALL be HALT and mem_err SHALL set.
REQ-018 mem_rdy=1 on the same cycle the count reaches MEM_TO SHALL win (->WRITEBACK, no error).
REQ-019 halted SHALL be 1 exactly in HALT; mem_err SHALL remain 1 until reset.
REQ-020 Minimum instruction latency SHALL be 4 clocks (FETCH..WRITEBACK); LOD/STR SHALL take 5 plus wait cycles.

Reset
REQ-021 rst_f=0 SHALL force START0 and clear latched fields, wait counter and mem_err asynchronously, from any state including MEM mid-wait.
REQ-022 During reset, pc_rst=1 and all other outputs 0 (dm_we drops immediately).

Structure
REQ-023 Opcode constants, state encoding and alu_op encodings SHALL reside in shared package sisc_pkg.
REQ-024 Branch-condition evaluation SHALL be sub-module sisc_br_eval (combinational, parametrised STAT_W).

Verification
REQ-025 Reset release, opcode=1 held -> state_o 0,1,2,3,4,6,2; rf_we=1 only in WRITEBACK; alu_op=10, stat_en=1 in EXECUTE.
REQ-026 BNE, mm=4'b0001, stat=4'b0000 -> EXECUTE pc_write=1, pc_sel=1, br_sel=0; stat=4'b0001 -> pc_write=0.
REQ-027 LOD, mem_rdy low 3 cycles -> MEM for 4 cycles, then WRITEBACK with rf_we=1, wb_sel=1.
REQ-028 STR, mem_rdy never asserted, MEM_TO=15 -> 16 MEM cycles with dm_we=1, then HALT, halted=1, mem_err=1.
REQ-029 HLT -> HALT held for 20 cycles; rst_f pulsed low mid-MEM -> state_o=0, dm_we=0, mem_err=0 immediately.
